// File: rtl/ofifo_aligned.sv
// Column-aligned output FIFO for systolic-array partial sums: per-column write, full-row pop.
// Optional macro OFIFO_RELU_EN clamps negative popped words to zero.
module ofifo_aligned #(
  parameter int col          = 8,
  parameter int psum_bw      = 16,
  parameter int depth        = 64,
  parameter int afull_thresh = 56
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [col*psum_bw-1:0]     in,
  input  logic [col-1:0]             wr,
  input  logic                       rd,
  input  logic                       flush,
  output logic [col*psum_bw-1:0]     out,
  output logic                       o_out_valid,
  output logic                       o_valid,
  output logic                       o_full,
  output logic                       o_ready,
  output logic                       o_afull,
  output logic [$clog2(depth):0]     o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [psum_bw-1:0]   mem_r [col][depth];
  logic [AW-1:0]        wr_ptr_r [col];
  logic [CW-1:0]        cnt_r [col];
  logic [AW-1:0]        rd_ptr_r;
  logic [col*psum_bw-1:0] out_r;
  logic                 out_valid_r;
  logic                 overflow_r;
  logic                 underflow_r;

  logic                 valid_s;
  logic                 full_s;
  logic                 afull_s;
  logic [CW-1:0]        min_cnt_s;
  logic                 pop_s;
  logic                 underflow_set_s;
  logic [col-1:0]       wr_acc_s;
  logic [col-1:0]       drop_s;
  logic [col*psum_bw-1:0] pop_row_s;

  function automatic logic [psum_bw-1:0] relu(input logic [psum_bw-1:0] w);
`ifdef OFIFO_RELU_EN
    if (w[psum_bw-1]) begin
      return {psum_bw{1'b0}};
    end else begin
      return w;
    end
`else
    return w;
`endif
  endfunction

  // Status flags and minimum occupancy derived from the registered counts.
  always_comb begin
    valid_s   = 1'b1;
    full_s    = 1'b0;
    afull_s   = 1'b0;
    min_cnt_s = cnt_r[0];
    for (int i = 0; i < col; i++) begin
      if (cnt_r[i] == {CW{1'b0}}) valid_s = 1'b0;
      else                        valid_s = valid_s;
      if (cnt_r[i] == CW'(depth)) full_s = 1'b1;
      else                        full_s = full_s;
      if (cnt_r[i] >= CW'(afull_thresh)) afull_s = 1'b1;
      else                               afull_s = afull_s;
      if (cnt_r[i] < min_cnt_s) min_cnt_s = cnt_r[i];
      else                      min_cnt_s = min_cnt_s;
    end
  end

  // Pop/write acceptance; flush swallows both strobes for the cycle.
  always_comb begin
    pop_s           = rd & valid_s & ~flush;
    underflow_set_s = rd & ~valid_s & ~flush;
    wr_acc_s        = {col{1'b0}};
    drop_s          = {col{1'b0}};
    for (int i = 0; i < col; i++) begin
      if (wr[i] && !flush) begin
        if ((cnt_r[i] != CW'(depth)) || pop_s) wr_acc_s[i] = 1'b1;
        else                                   drop_s[i]   = 1'b1;
      end else begin
        wr_acc_s[i] = 1'b0;
      end
    end
  end

  // Row read at the shared pointer, optionally clamped.
  always_comb begin
    pop_row_s = {(col*psum_bw){1'b0}};
    for (int i = 0; i < col; i++) begin
      pop_row_s[i*psum_bw +: psum_bw] = relu(mem_r[i][rd_ptr_r]);
    end
  end

  // Storage array; contents need no reset since counts gate visibility.
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (wr_acc_s[i]) mem_r[i][wr_ptr_r[i]] <= in[i*psum_bw +: psum_bw];
    end
  end

  // Pointers and per-channel counts.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_r <= {AW{1'b0}};
      for (int i = 0; i < col; i++) begin
        wr_ptr_r[i] <= {AW{1'b0}};
        cnt_r[i]    <= {CW{1'b0}};
      end
    end else begin
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      for (int i = 0; i < col; i++) begin
        if (wr_acc_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
        case ({wr_acc_s[i], pop_s})
          2'b10:   cnt_r[i] <= cnt_r[i] + CW'(1);
          2'b01:   cnt_r[i] <= cnt_r[i] - CW'(1);
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
    end
  end

  // Output row register, valid strobe and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r       <= {(col*psum_bw){1'b0}};
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r | (|drop_s);
      underflow_r <= underflow_r | underflow_set_s;
      if (pop_s) begin
        out_r       <= pop_row_s;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out         = out_r;
  assign o_out_valid = out_valid_r;
  assign o_overflow  = overflow_r;
  assign o_underflow = underflow_r;
  assign o_valid     = valid_s;
  assign o_full      = full_s;
  assign o_ready     = ~full_s;
  assign o_afull     = afull_s;
  assign o_count     = min_cnt_s;

endmodule

// File: tb/tb_ofifo_aligned.sv
// Directed self-checking bench for ofifo_aligned (default parameters).
module tb_ofifo_aligned;

  localparam int COL = 8;
  localparam int BW  = 16;

  logic              clk;
  logic              reset;
  logic [COL*BW-1:0] din;
  logic [COL-1:0]    wr;
  logic              rd;
  logic              flush;
  logic [COL*BW-1:0] dout;
  logic              o_out_valid, o_valid, o_full, o_ready, o_afull;
  logic [6:0]        o_count;
  logic              o_overflow, o_underflow;

  int checks = 0;
  int errors = 0;

  ofifo_aligned dut (
    .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd), .flush(flush),
    .out(dout), .o_out_valid(o_out_valid), .o_valid(o_valid), .o_full(o_full),
    .o_ready(o_ready), .o_afull(o_afull), .o_count(o_count),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row where channel c holds {c, v[7:0]}, so channel mixing is visible.
  function automatic logic [COL*BW-1:0] mk(input int v);
    logic [COL*BW-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = 16'((c << 8) | (v & 8'hFF));
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr = '0; rd = 1'b0; flush = 1'b0; din = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    checks++; if (o_full !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL reset_full got full=%b ready=%b exp 0/1", o_full, o_ready); end
    checks++; if (o_afull !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", o_afull); end
    checks++; if (o_count !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", o_count); end
    checks++; if (dout !== '0 || o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out got %h/%b exp 0/0", dout, o_out_valid); end
    checks++; if (o_overflow !== 1'b0 || o_underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", o_overflow, o_underflow); end
  endtask

  task automatic test_stagger();
    logic [COL*BW-1:0] exp_row;
    exp_row = '0;
    for (int i = 0; i < COL; i++) begin
      din = '0;
      din[i*BW +: BW] = 16'(16'h0010 + i);
      exp_row[i*BW +: BW] = 16'(16'h0010 + i);
      wr = COL'(1 << i);
      step();
      checks++;
      if (o_valid !== (i == COL-1)) begin errors++; $display("FAIL stagger_valid ch%0d got %b exp %b", i, o_valid, (i == COL-1)); end
    end
    wr = '0;
    checks++; if (o_count !== 7'd1) begin errors++; $display("FAIL stagger_count got %0d exp 1", o_count); end
    rd = 1'b1;
    step();
    rd = 1'b0;
    checks++; if (o_out_valid !== 1'b1) begin errors++; $display("FAIL pop_valid got %b exp 1", o_out_valid); end
    checks++; if (dout !== exp_row) begin errors++; $display("FAIL pop_data got %h exp %h", dout, exp_row); end
    checks++; if (o_valid !== 1'b0 || o_count !== 7'd0) begin errors++; $display("FAIL pop_empty got v=%b c=%0d exp 0/0", o_valid, o_count); end
    step();
    checks++; if (o_out_valid !== 1'b0 || dout !== exp_row) begin errors++; $display("FAIL pop_hold got %b/%h exp 0/%h", o_out_valid, dout, exp_row); end
  endtask

  task automatic test_fill();
    do_reset();
    wr = '1;
    for (int k = 0; k < 64; k++) begin
      din = mk(k);
      step();
      checks++;
      if (o_afull !== (k + 1 >= 56)) begin errors++; $display("FAIL fill_afull cnt=%0d got %b exp %b", k + 1, o_afull, (k + 1 >= 56)); end
    end
    checks++; if (o_full !== 1'b1 || o_ready !== 1'b0 || o_count !== 7'd64) begin errors++; $display("FAIL fill_full got f=%b r=%b c=%0d exp 1/0/64", o_full, o_ready, o_count); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %b exp 0", o_overflow); end
    din = mk(8'hEE);
    step();
    checks++; if (o_overflow !== 1'b1 || o_count !== 7'd64) begin errors++; $display("FAIL overflow got ovf=%b c=%0d exp 1/64", o_overflow, o_count); end
    din = mk(8'hAB);
    rd = 1'b1;
    step();
    wr = '0;
    checks++; if (o_count !== 7'd64 || o_out_valid !== 1'b1 || dout !== mk(0)) begin errors++; $display("FAIL wr_with_rd got c=%0d v=%b d=%h exp 64/1/%h", o_count, o_out_valid, dout, mk(0)); end
    for (int j = 1; j <= 64; j++) begin
      step();
      checks++;
      if (dout !== ((j == 64) ? mk(8'hAB) : mk(j)) || o_out_valid !== 1'b1) begin errors++; $display("FAIL drain row%0d got %h exp %h", j, dout, (j == 64) ? mk(8'hAB) : mk(j)); end
    end
    rd = 1'b0;
    checks++; if (o_count !== 7'd0 || o_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got c=%0d v=%b exp 0/0", o_count, o_valid); end
  endtask

  task automatic test_underflow();
    rd = 1'b1;
    step();
    rd = 1'b0;
    checks++; if (o_out_valid !== 1'b0 || o_underflow !== 1'b1) begin errors++; $display("FAIL underflow got ov=%b uf=%b exp 0/1", o_out_valid, o_underflow); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (o_underflow !== 1'b1 || o_overflow !== 1'b1) begin errors++; $display("FAIL sticky_flush got uf=%b ovf=%b exp 1/1", o_underflow, o_overflow); end
    do_reset();
    checks++; if (o_underflow !== 1'b0 || o_overflow !== 1'b0) begin errors++; $display("FAIL sticky_reset got uf=%b ovf=%b exp 0/0", o_underflow, o_overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr = '1;
    for (int v = 0; v < 200; v++) begin
      din = mk(v);
      rd = (v >= 1);
      step();
      if (v >= 1) begin
        checks++;
        if (dout !== mk(v - 1) || o_out_valid !== 1'b1 || o_count !== 7'd1) begin errors++; $display("FAIL b2b row%0d got %h v=%b c=%0d exp %h/1/1", v - 1, dout, o_out_valid, o_count, mk(v - 1)); end
      end
    end
    rd = 1'b0;
    din = mk(200); step();
    din = mk(201); step();
    wr = '0;
    checks++; if (o_count !== 7'd3) begin errors++; $display("FAIL pre_flush_count got %0d exp 3", o_count); end
    flush = 1'b1; wr = '1; rd = 1'b1;
    step();
    flush = 1'b0; wr = '0; rd = 1'b0;
    checks++; if (o_count !== 7'd0 || o_valid !== 1'b0 || o_out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got c=%0d v=%b ov=%b exp 0/0/0", o_count, o_valid, o_out_valid); end
    checks++; if (dout !== mk(198)) begin errors++; $display("FAIL flush_hold got %h exp %h", dout, mk(198)); end
    checks++; if (o_underflow !== 1'b0 || o_overflow !== 1'b0) begin errors++; $display("FAIL flush_ignores got uf=%b ovf=%b exp 0/0", o_underflow, o_overflow); end
    step();
    checks++; if (o_count !== 7'd0) begin errors++; $display("FAIL flush_no_write got %0d exp 0", o_count); end
  endtask

  task automatic test_relu();
    logic [BW-1:0] exp3;
`ifdef OFIFO_RELU_EN
    exp3 = 16'h0000;
`else
    exp3 = 16'hFFF0;
`endif
    do_reset();
    din = mk(5);
    din[3*BW +: BW] = 16'hFFF0;
    wr = '1;
    step();
    wr = '0; rd = 1'b1;
    step();
    rd = 1'b0;
    checks++; if (dout[3*BW +: BW] !== exp3) begin errors++; $display("FAIL relu_ch3 got %h exp %h", dout[3*BW +: BW], exp3); end
    checks++; if (dout[2*BW +: BW] !== 16'h0205) begin errors++; $display("FAIL relu_ch2 got %h exp 0205", dout[2*BW +: BW]); end
  endtask

  initial begin
    test_reset();
    test_stagger();
    test_fill();
    test_underflow();
    test_back_to_back();
    test_relu();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
